// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the control path: opcode type, the HALT opcode, the
// issue FSM state encoding and default datapath widths used by the fetch
// sequencer, control unit and instruction memory.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_WIDTH_DEF    = 8;
    localparam int INSTR_WIDTH_DEF = 16;
    localparam int IMM_WIDTH_DEF   = 11;
    localparam int OPCODE_WIDTH    = 5;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
// Combinational next-PC selection. Combines the branch class decoded by the
// control unit with the registered ALU flags. A taken branch loads the low
// PC_WIDTH bits of the immediate; otherwise the PC increments and wraps.
//
// Ports:
//   is_jump/is_jz/is_jnz/is_jl/is_jg  in   branch class from the control unit
//   flag_z/flag_l/flag_g              in   ALU flags (zero, less, greater)
//   pc                                in   address of the current instruction
//   imm                               in   immediate/target field
//   taken                             out  branch condition satisfied
//   next_pc                           out  address of the next instruction
// ----------------------------------------------------------------------------
module branch_resolve #(
    parameter int PC_WIDTH  = 8,
    parameter int IMM_WIDTH = 11   // must be >= PC_WIDTH
) (
    input  logic                 is_jump,
    input  logic                 is_jz,
    input  logic                 is_jnz,
    input  logic                 is_jl,
    input  logic                 is_jg,
    input  logic                 flag_z,
    input  logic                 flag_l,
    input  logic                 flag_g,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 taken,
    output logic [PC_WIDTH-1:0]  next_pc
);

    always_comb begin
        taken = is_jump
              | (is_jz  &  flag_z)
              | (is_jnz & ~flag_z)
              | (is_jl  &  flag_l)
              | (is_jg  &  flag_g);
        // Target is truncated to the PC width; the increment wraps naturally.
        next_pc = taken ? imm[PC_WIDTH-1:0] : pc + 1'b1;
    end

    // Upper immediate bits are deliberately ignored as a branch target.
    generate
        if (IMM_WIDTH > PC_WIDTH) begin : g_imm_hi
            logic unused_imm_hi;
            assign unused_imm_hi = ^imm[IMM_WIDTH-1:PC_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-issue FSM: FETCH -> LOAD -> EXEC -> FETCH, with EXEC -> HALT.
// FETCH presents the PC to the synchronous instruction memory, LOAD captures
// the returned word into the instruction register, EXEC presents opcode/imm to
// the combinational control unit and resolves the next PC in the same cycle.
// stall holds EXEC. HALT is absorbing until reset.
//
// Build option: define SINGLE_STEP_EN to add a 'step' input that gates EXEC
// advancement (one instruction retires per EXEC visit with step=1).
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   imem_addr / imem_data instruction memory address out, read data in
//   opcode, imm           current instruction fields to the control unit
//   instr_valid           high in EXEC
//   pc                    address of the current instruction
//   is_jump..is_jg        branch class from the control unit
//   flag_z/l/g            ALU flags
//   stall                 holds EXEC (data-memory busy)
//   halted                high in HALT
//   step                  (SINGLE_STEP_EN only) permits EXEC to advance
// ----------------------------------------------------------------------------
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int IMM_WIDTH   = IMM_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [4:0]             opcode,
    output logic [IMM_WIDTH-1:0]   imm,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic                   is_jump,
    input  logic                   is_jz,
    input  logic                   is_jnz,
    input  logic                   is_jl,
    input  logic                   is_jg,
    input  logic                   flag_z,
    input  logic                   flag_l,
    input  logic                   flag_g,
    input  logic                   stall,
`ifdef SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   halted
);

    fsm_state_t             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;

    logic                   advance;
    logic                   taken;
    logic [PC_WIDTH-1:0]    next_pc;
    opcode_t                ir_op;

    assign ir_op = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];

`ifdef SINGLE_STEP_EN
    assign advance = ~stall & step;
`else
    assign advance = ~stall;
`endif

    branch_resolve #(
        .PC_WIDTH  (PC_WIDTH),
        .IMM_WIDTH (IMM_WIDTH)
    ) u_branch_resolve (
        .is_jump (is_jump),
        .is_jz   (is_jz),
        .is_jnz  (is_jnz),
        .is_jl   (is_jl),
        .is_jg   (is_jg),
        .flag_z  (flag_z),
        .flag_l  (flag_l),
        .flag_g  (flag_g),
        .pc      (pc_q),
        .imm     (ir_q[IMM_WIDTH-1:0]),
        .taken   (taken),
        .next_pc (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            FETCH: state_d = LOAD;
            LOAD: begin
                ir_d    = imem_data;
                state_d = EXEC;
            end
            EXEC: begin
                // Halt has priority over any branch decode; the PC stays put.
                if (advance) begin
                    if (ir_op == OP_HALT) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // opcode/imm come straight from the IR: zero after reset, stable through
    // a stall, and OP_HALT while halted since the IR is never reloaded.
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = ir_op;
    assign imm         = ir_q[IMM_WIDTH-1:0];
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALT);

    // taken is consumed through next_pc; keep it visible for debug only.
    logic unused_taken;
    assign unused_taken = taken;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Program-level reference model: each round builds a 256-word program, walks
// it instruction by instruction with the branch rules to produce the expected
// retirement trace, and a monitor compares every EXEC visit against it.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import cpu_pkg::*;

    localparam int K_MAX = 30;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = '0;
    logic [4:0]  opcode;
    logic [10:0] imm;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        is_jump, is_jz, is_jnz, is_jl, is_jg;
    logic        flag_z = 1'b0, flag_l = 1'b0, flag_g = 1'b0;
    logic        stall = 1'b0;
    logic        halted;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .opcode(opcode), .imm(imm), .instr_valid(instr_valid), .pc(pc),
        .is_jump(is_jump), .is_jz(is_jz), .is_jnz(is_jnz), .is_jl(is_jl), .is_jg(is_jg),
        .flag_z(flag_z), .flag_l(flag_l), .flag_g(flag_g), .stall(stall),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .halted(halted)
    );

    // Instruction memory: synchronous read, one cycle latency.
    logic [15:0] mem [256];
    always @(posedge clk) imem_data <= mem[imem_addr];

    // Stand-in control unit. OP_HALT also raises is_jump to exercise halt priority.
    always_comb begin
        is_jump = (opcode == 5'd1) || (opcode == OP_HALT);
        is_jz   = (opcode == 5'd2);
        is_jnz  = (opcode == 5'd3);
        is_jl   = (opcode == 5'd4);
        is_jg   = (opcode == 5'd5);
    end

    typedef struct {
        logic [7:0]  pc;
        logic [4:0]  op;
        logic [10:0] imm;
        int          st;
    } exp_t;

    exp_t        exp_q[$];
    logic [2:0]  flag_seq [64];
    int          stall_len [64];
    int          n_cmp = 0, n_err = 0;
    logic        halts;
    logic [7:0]  halt_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, {24'd0, pc}, 0);
        chk({tag, "_imem_addr"}, {24'd0, imem_addr}, 0);
        chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 0);
        chk({tag, "_halted"}, {31'd0, halted}, 0);
        chk({tag, "_opcode"}, {27'd0, opcode}, 0);
        chk({tag, "_imm"}, {21'd0, imm}, 0);
    endtask

    // ---------------- driver: flags per instruction, stall per EXEC ----------
    logic running = 1'b0;
    int   idx = 0, stall_rem = 0;

    always @(negedge clk) begin
        if (running) begin
            {flag_z, flag_l, flag_g} = flag_seq[idx];
            if (instr_valid) begin
                if (stall_rem > 0) begin
                    stall = 1'b1;
                    stall_rem--;
                end else begin
                    stall = 1'b0;
                    if (idx < 63) idx++;
                    stall_rem = stall_len[idx];
                end
            end else begin
                stall = 1'($urandom % 2);   // must be ignored outside EXEC
            end
        end
    end

    // ---------------- monitor --------------------------------------------------
    logic in_exec = 1'b0, cur_has = 1'b0, seen_exec = 1'b0;
    int   gap = 0, exec_len = 0;
    exp_t cur;

    always @(negedge clk) begin
        #2;
        if (!reset_n) begin
            in_exec = 1'b0; cur_has = 1'b0; seen_exec = 1'b0; gap = 0;
        end else if (instr_valid) begin
            if (!in_exec) begin
                if (seen_exec) chk("fetch_load_gap", gap, 2);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    cur_has = 1'b1;
                    chk("exec_opcode", {27'd0, opcode}, {27'd0, cur.op});
                    chk("exec_imm", {21'd0, imm}, {21'd0, cur.imm});
                    chk("exec_imem_addr", {24'd0, imem_addr}, {24'd0, cur.pc});
                end else begin
                    cur_has = 1'b0;
                end
                exec_len = 0; in_exec = 1'b1; seen_exec = 1'b1;
            end
            exec_len++;
            if (cur_has) chk("exec_pc", {24'd0, pc}, {24'd0, cur.pc});
            gap = 0;
        end else begin
            if (in_exec && cur_has) chk("exec_len", exec_len, cur.st + 1);
            in_exec = 1'b0;
            gap++;
        end
    end

    // ---------------- program generation and reference model -----------------
    function automatic logic [15:0] rand_word(input bit allow_halt);
        int r;
        logic [4:0] op;
        r = $urandom % 16;
        if (r < 6 || r == 13 || r == 14) op = 5'(6 + $urandom % 25);
        else if (r < 8)  op = 5'd1;
        else if (r < 10) op = 5'd2;
        else if (r == 10) op = 5'd3;
        else if (r == 11) op = 5'd4;
        else if (r == 12) op = 5'd5;
        else op = allow_halt ? OP_HALT : 5'd6;
        return {op, 11'($urandom)};
    endfunction

    function automatic logic [15:0] nop_word();
        return {5'(6 + $urandom % 25), 11'($urandom)};
    endfunction

    task automatic build(input int mode);
        for (int i = 0; i < 256; i++) mem[i] = (mode == 3) ? rand_word(1'b1) : nop_word();
        for (int k = 0; k < 64; k++) begin
            flag_seq[k]  = 3'($urandom);
            stall_len[k] = (mode == 0) ? 0 : (($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        if (mode == 1) begin
            mem[8'h00] = {5'd1, 11'h7AB};   // jump, target truncates to 0xAB
            mem[8'hAB] = {5'd1, 11'h4FF};   // jump to 0xFF, then wrap to 0
        end
        if (mode == 2) begin
            mem[3] = {5'd1, 11'h005};       // jump held by a 4-cycle stall
            stall_len[3] = 4;
            mem[7] = {OP_HALT, 11'h033};    // halt with is_jump also raised
        end
    endtask

    task automatic run_model(input int k_max);
        logic [7:0]  p;
        logic [15:0] w;
        logic [4:0]  op;
        logic        z, l, g, t;
        exp_t        e;
        p = 8'd0; halts = 1'b0; halt_pc = 8'd0;
        exp_q.delete();
        for (int k = 0; k < k_max; k++) begin
            w = mem[p];
            op = w[15:11];
            e.pc = p; e.op = op; e.imm = w[10:0]; e.st = stall_len[k];
            exp_q.push_back(e);
            if (op == OP_HALT) begin
                halts = 1'b1; halt_pc = p;
                break;
            end
            {z, l, g} = flag_seq[k];
            case (op)
                5'd1: t = 1'b1;
                5'd2: t = z;
                5'd3: t = !z;
                5'd4: t = l;
                5'd5: t = g;
                default: t = 1'b0;
            endcase
            p = t ? w[7:0] : 8'(p + 8'd1);
        end
    endtask

    // ---------------- rounds --------------------------------------------------
    task automatic do_round(input int mode, input int k_max);
        bit done;
        running = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        stall = 1'b0;
        build(mode);
        run_model(k_max);
        idx = 0;
        stall_rem = stall_len[0];
        repeat (2) @(negedge clk);
        #3;
        chk_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;
        running = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !in_exec) done = 1'b1;
        end
        chk("drain_in_time", {31'd0, done}, 1);
        running = 1'b0;
        if (halts) begin
            for (int r = 0; r < 2; r++) begin
                chk("halt_halted", {31'd0, halted}, 1);
                chk("halt_valid", {31'd0, instr_valid}, 0);
                chk("halt_pc", {24'd0, pc}, {24'd0, halt_pc});
                chk("halt_imem_addr", {24'd0, imem_addr}, {24'd0, halt_pc});
                chk("halt_opcode", {27'd0, opcode}, {27'd0, OP_HALT});
                repeat (3) @(negedge clk);
                #3;
            end
        end else begin
            // Reset arriving while EXEC is stalled must abort cleanly.
            stall = 1'b1;
            for (int c = 0; c < 10 && !instr_valid; c++) @(negedge clk);
            repeat (2) @(negedge clk);
            #3;
            chk("stalled_exec_valid", {31'd0, instr_valid}, 1);
            @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            #3;
            chk_reset("reset_in_stall");
            stall = 1'b0;
        end
    endtask

    initial begin
        do_round(0, 12);        // straight-line, no stalls
        do_round(1, K_MAX);     // truncated jump target and PC wrap
        do_round(2, K_MAX);     // stalled jump, halt at 7 with jump asserted
        for (int r = 0; r < 8; r++) do_round(3, K_MAX);
        do_round(0, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
